// File: rtl/spi_bus_pkg.sv
// ============================================================================
// Module   : spi_bus_pkg
// Brief    : Shared widths and FSM state type for the SPI-to-system-bus path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_bus_pkg;

    localparam int SPI_ADDR_W = 17;
    localparam int SPI_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SLOT = 3'd1,
        ST_STROBE    = 3'd2,
        ST_ACK       = 3'd3,
        ST_REARM     = 3'd4
    } spi_bus_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_bus_master_if.sv
// ============================================================================
// Module   : spi_bus_master_if
// Brief    : Bridge request/response, slot strobe and system bus signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_bus_master_if;

    logic [spi_bus_pkg::SPI_ADDR_W-1:0] spi_addr_i;
    logic [spi_bus_pkg::SPI_DATA_W-1:0] spi_data_i;
    logic                               spi_rw_ni;
    logic                               spi_valid_i;
    logic                               spi_ready_o;
    logic [spi_bus_pkg::SPI_DATA_W-1:0] spi_data_o;
    logic                               spi_slot_i;
    logic                               spi_pending_o;
    logic [spi_bus_pkg::SPI_ADDR_W-1:0] bus_addr_o;
    logic [spi_bus_pkg::SPI_DATA_W-1:0] bus_data_o;
    logic [spi_bus_pkg::SPI_DATA_W-1:0] bus_data_i;
    logic                               bus_we_o;
    logic                               bus_en_o;

    modport master (
        input  spi_addr_i, spi_data_i, spi_rw_ni, spi_valid_i, spi_slot_i, bus_data_i,
        output spi_ready_o, spi_data_o, spi_pending_o, bus_addr_o, bus_data_o,
               bus_we_o, bus_en_o
    );

    modport slave (
        output spi_addr_i, spi_data_i, spi_rw_ni, spi_valid_i, spi_slot_i, bus_data_i,
        input  spi_ready_o, spi_data_o, spi_pending_o, bus_addr_o, bus_data_o,
               bus_we_o, bus_en_o
    );

endinterface

`default_nettype wire

// File: rtl/bus_strobe_timer.sv
// ============================================================================
// Module   : bus_strobe_timer
// Brief    : 4-bit loadable down-counter that stops at zero; times bus strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_strobe_timer (
    input  wire logic       clk_sys_i,
    input  wire logic       sys_reset_ni,
    input  wire logic       load_i,
    input  wire logic [3:0] load_val_i,
    input  wire logic       en_i,
    output logic            zero_o
);

    logic [3:0] r_count;

    always_ff @(posedge clk_sys_i or negedge sys_reset_ni) begin
        if (!sys_reset_ni) begin
            r_count <= 4'd0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (en_i && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign zero_o = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/spi_bus_master.sv
// ============================================================================
// Module   : spi_bus_master
// Brief    : Runs one fixed-length system bus cycle per SPI bridge request,
//            launched in a timing-generator slot; returns data and a ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_bus_master
    import spi_bus_pkg::*;
#(
    parameter int STROBE_CYCLES = 3
) (
    input  wire logic         clk_sys_i,
    input  wire logic         sys_reset_ni,
    spi_bus_master_if.master  bus
);

    localparam logic [3:0] c_strobe_load = 4'(STROBE_CYCLES - 1);

    spi_bus_state_t             r_state;
    spi_bus_state_t             w_state_nxt;

    logic [SPI_ADDR_W-1:0]      r_addr;
    logic [SPI_DATA_W-1:0]      r_wdata;
    logic                       r_rw;
    logic [SPI_ADDR_W-1:0]      r_bus_addr;
    logic [SPI_DATA_W-1:0]      r_bus_data;
    logic                       r_bus_we;
    logic                       r_bus_en;
    logic                       r_ready;
    logic                       r_pending;
    logic [SPI_DATA_W-1:0]      r_rdata;

    logic                       w_latch;
    logic                       w_launch;
    logic                       w_capture;
    logic                       w_timer_zero;

    bus_strobe_timer u_strobe_timer (
        .clk_sys_i    (clk_sys_i),
        .sys_reset_ni (sys_reset_ni),
        .load_i       (w_launch),
        .load_val_i   (c_strobe_load),
        .en_i         (r_state == ST_STROBE),
        .zero_o       (w_timer_zero)
    );

    always_ff @(posedge clk_sys_i or negedge sys_reset_ni) begin
        if (!sys_reset_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.spi_valid_i) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_WAIT_SLOT;
                end
            end
            ST_WAIT_SLOT: begin
                // A dropped valid means the bridge was reset; abandon before any bus activity.
                if (!bus.spi_valid_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.spi_slot_i) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (w_timer_zero) begin
                    w_capture   = r_rw;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_REARM;
            end
            ST_REARM: begin
                if (!bus.spi_valid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every output comes straight off a flop.
    always_ff @(posedge clk_sys_i or negedge sys_reset_ni) begin
        if (!sys_reset_ni) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rw       <= 1'b0;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_bus_we   <= 1'b0;
            r_bus_en   <= 1'b0;
            r_ready    <= 1'b0;
            r_pending  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_pending <= (w_state_nxt == ST_WAIT_SLOT);
            r_bus_en  <= (w_state_nxt == ST_STROBE);
            r_bus_we  <= (w_state_nxt == ST_STROBE) && !r_rw;
            r_ready   <= (w_state_nxt == ST_ACK);
            if (w_latch) begin
                r_addr  <= bus.spi_addr_i;
                r_wdata <= bus.spi_data_i;
                r_rw    <= bus.spi_rw_ni;
            end
            if (w_launch) begin
                r_bus_addr <= r_addr;
                r_bus_data <= r_wdata;
            end
            if (w_capture) begin
                r_rdata <= bus.bus_data_i;
            end
        end
    end

    assign bus.spi_ready_o   = r_ready;
    assign bus.spi_data_o    = r_rdata;
    assign bus.spi_pending_o = r_pending;
    assign bus.bus_addr_o    = r_bus_addr;
    assign bus.bus_data_o    = r_bus_data;
    assign bus.bus_we_o      = r_bus_we;
    assign bus.bus_en_o      = r_bus_en;

endmodule

`default_nettype wire

// File: doc/spi_bus_master.md
# spi_bus_master

Executes the single memory/IO transfer requested by the SPI bridge on the PET system bus. Sits directly downstream of the SPI bridge: it consumes the bridge's address/data/direction/valid request, waits for a bus slot from the timing generator, drives a fixed-length bus cycle, and returns read data plus a one-cycle ready pulse. Also tells the timing generator when an SPI transfer is pending.

## Interface
- `STROBE_CYCLES`, 3: number of `clk_sys_i` cycles `bus_en_o` is held (legal range 1..15).
- `clk_sys_i`  in  1  system clock; all logic is in this domain.
- `sys_reset_ni`  in  1  reset, asynchronous assert, active-low.
- `spi_addr_i`  in  17  bridge address.
- `spi_data_i`  in  8  bridge write data.
- `spi_rw_ni`  in  1  1 = read, 0 = write.
- `spi_valid_i`  in  1  bridge request level; held until ready is seen.
- `spi_ready_o`  out  1  one-cycle completion pulse to the bridge.
- `spi_data_o`  out  8  read data returned to the bridge; stable from ready until next read completes.
- `spi_slot_i`  in  1  one-cycle strobe from the timing generator: the next cycle's bus is free for SPI.
- `spi_pending_o`  out  1  high while a request waits for a slot.
- `bus_addr_o`  out  17  system bus address.
- `bus_data_o`  out  8  system bus write data.
- `bus_data_i`  in  8  system bus read data.
- `bus_we_o`  out  1  write enable; valid only while `bus_en_o`.
- `bus_en_o`  out  1  bus cycle active.

## Operation
- States: IDLE, WAIT_SLOT, STROBE, ACK, REARM.
- IDLE: `spi_valid_i`=1 -> latch addr/data/rw into internal registers, go WAIT_SLOT. Inputs are not sampled again until the next request.
- WAIT_SLOT: `spi_pending_o`=1. On `spi_slot_i`=1: load strobe counter with `STROBE_CYCLES`-1, drive latched addr/data, `bus_we_o` = !rw, `bus_en_o`=1, go STROBE. Slot pulses in other states are ignored.
- STROBE: counter decrements each cycle; at counter = 0, if read, capture `bus_data_i` into `spi_data_o`; drop `bus_en_o`/`bus_we_o`; go ACK.
- ACK: `spi_ready_o`=1 for exactly one cycle; go REARM.
- REARM: wait for `spi_valid_i`=0, then go IDLE. This prevents a still-high valid level from launching a duplicate transfer.
- `spi_valid_i` dropping in WAIT_SLOT (bridge reset by CS deassert): abandon, go IDLE, no bus cycle.
- `spi_valid_i` dropping in STROBE: bus cycle runs to completion. ACK is still issued and the bridge ignores it. A bus cycle is never truncated.
- Writes leave `spi_data_o` unchanged.
- Address is passed through as 17 bits. The bridge does any increment; this block does no arithmetic on the address.

## Timing
- Reset values: all outputs 0, `spi_data_o` = 8'h00, state IDLE, counter 0. A reset mid-STROBE drops `bus_en_o` immediately (asynchronously).
- Cycle 0: valid seen in IDLE. Cycle 1: earliest WAIT_SLOT, and `spi_pending_o` is high.
- Slot sampled high at cycle k: `bus_en_o` high for cycles k+1 .. k+STROBE_CYCLES.
- Read data is captured at the clock edge ending cycle k+STROBE_CYCLES.
- `spi_ready_o` is high in cycle k+STROBE_CYCLES+1, with `spi_data_o` already valid in that cycle.
- Minimum request-to-ready latency is STROBE_CYCLES+2 cycles, reached when the slot arrives in the first WAIT_SLOT cycle.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Shared package `spi_bus_pkg` holds:
  - the state enum `spi_bus_state_t`;
  - `SPI_ADDR_W` = 17 and `SPI_DATA_W` = 8, shared with the bridge.
- Sub-module `bus_strobe_timer`: a 4-bit loadable down-counter with load/enable/`zero_o`. It is reused later for the CPU-side strobe.
- Top-level target is about 150–200 lines.

## Test plan
- Write: addr 17'h08000, data 8'hA5, rw=0, slot 4 cycles after valid -> `bus_en_o` high 3 cycles with addr 17'h08000, data A5, we=1; one ready pulse 4 cycles after the slot.
- Read: addr 17'h1E810, rw=1, `bus_data_i`=8'h3C during the strobe -> `spi_data_o`=3C when ready pulses, `bus_we_o`=0 throughout; `spi_data_o` holds 3C after a subsequent write.
- Slot pulses while IDLE and during STROBE -> no extra bus cycle, exactly one `bus_en_o` burst per request.
- Valid held high 10 cycles after ready -> no second transfer. Valid low for 1 cycle, then high with a new addr -> second transfer uses the new addr.
- Valid drops in WAIT_SLOT -> `spi_pending_o` clears next cycle, no `bus_en_o`, no ready. Valid drops mid-STROBE -> full 3-cycle strobe, ready still pulses.
- `sys_reset_ni` asserted in the second STROBE cycle -> `bus_en_o` 0 immediately, all outputs at reset values. After release, a new request completes normally.
